// File: rtl/if_fetch_seq.sv
// Instruction-fetch sequencer: owns the fetch address, issues one outstanding
// imem read at a time, buffers returned words for decode and drives the PC register.
module if_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic        pc_wr,
  output logic [31:0] pc_next,
  output logic        fault,
  output logic [2:0]  dbg_state
);

  // Handshakes: a request is accepted on a cycle with imem_req & imem_gnt, and
  // exactly one imem_rvalid follows later; the decode slot transfers on a cycle
  // with id_valid & id_ready, and id_valid never drops without a transfer except
  // on redirect or reset.
  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        pc_wr_q, pc_wr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        fault_q, fault_d;

  logic        aligned;
  logic [31:0] pc_inc;

  assign aligned = (fetch_pc_q[1:0] == 2'b00);
  assign pc_inc  = fetch_pc_q + PC_STEP;

  assign imem_req  = (state_q == S_REQ) && aligned && !redirect;
  assign imem_addr = fetch_pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign pc_wr     = pc_wr_q;
  assign pc_next   = pc_next_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_next_d    = pc_next_q;
    pc_wr_d      = 1'b0;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    fault_d      = fault_q;

    if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end

    if (redirect) begin
      fetch_pc_d = redirect_target;
      pc_next_d  = redirect_target;
      pc_wr_d    = 1'b1;
      id_valid_d = 1'b0;
      fault_d    = 1'b0;
      // A read still in flight must be swallowed before the next request.
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (!aligned) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else if (imem_gnt) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            fetch_pc_d = pc_inc;
            pc_next_d  = pc_inc;
            pc_wr_d    = 1'b1;
            if (!id_valid_q || id_ready) begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rdata;
              id_pc_d    = fetch_pc_q;
              state_d    = S_REQ;
            end else begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = fetch_pc_q;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            id_valid_d = 1'b1;
            id_instr_d = hold_instr_q;
            id_pc_d    = hold_pc_q;
            state_d    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      pc_next_q    <= RESET_PC;
      pc_wr_q      <= 1'b0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'd0;
      id_pc_q      <= 32'd0;
      hold_instr_q <= 32'd0;
      hold_pc_q    <= 32'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_next_q    <= pc_next_d;
      pc_wr_q      <= pc_wr_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      fault_q      <= fault_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_seq.sv
// Bench for if_fetch_seq: behavioural imem, random decode back-pressure and
// redirects, with a monitor checking the delivered instruction stream and PC writes.
module tb_if_fetch_seq;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [2:0]  ST_HOLD  = 3'd2;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        pc_wr;
  logic [31:0] pc_next;
  logic        fault;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected architectural instruction addresses still to reach decode.
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] model_fetch;

  // Stimulus knobs shared between the directed sequence and the driver.
  int          gnt_pct = 100;
  int          ready_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  int          rnd_redir_pct = 0;
  bit          redir_fire = 0;
  int          redir_mode = 0;
  logic [31:0] redir_tgt_k = 32'd0;

  // Behavioural memory state.
  bit          pend = 0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_lat = 0;

  if_fetch_seq #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .pc_wr(pc_wr), .pc_next(pc_next), .fault(fault), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == RESET_PC) return 32'h2008_0005;
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(99);
    if (r < 5) return RESET_PC + (32'($urandom_range(255)) << 2) + 32'($urandom_range(3, 1));
    if (r < 12) return 32'hFFFF_FFF8;
    return RESET_PC + (32'($urandom_range(1023)) << 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: imem model, decode ready, redirects ----------------
  initial begin
    bit          resp;
    bit          do_redir;
    logic [31:0] tgt;
    redirect = 1'b0; redirect_target = 32'd0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
        redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
        continue;
      end
      resp = pend && (pend_lat == 0);
      imem_rvalid = resp;
      imem_rdata  = resp ? mem_fn(pend_addr) : $urandom;
      if (pend && !resp) pend_lat--;
      do_redir = 1'b0;
      tgt = $urandom;
      if (redir_fire) begin
        case (redir_mode)
          0:       do_redir = 1'b1;
          1:       do_redir = resp;
          default: do_redir = pend && !resp;
        endcase
        if (do_redir) begin
          tgt = redir_tgt_k;
          redir_fire = 0;
        end
      end else if ($urandom_range(99) < rnd_redir_pct) begin
        do_redir = 1'b1;
        tgt = rand_target();
      end
      redirect = do_redir;
      redirect_target = tgt;
      id_ready = ($urandom_range(99) < ready_pct);
      #1;
      imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
      if (resp) pend = 0;
      if (imem_gnt) begin
        chk("one_outstanding", {31'd0, pend}, 32'd0);
        pend = 1;
        pend_addr = imem_addr;
        pend_lat = $urandom_range(lat_max, lat_min);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit          s_ok, s_redir, s_rvalid;
    logic [31:0] s_tgt;
    logic [31:0] e;
    s_ok = 0; s_redir = 0; s_rvalid = 0; s_tgt = 32'd0;
    exp_next = RESET_PC;
    model_fetch = RESET_PC;
    forever begin
      @(negedge clk); #2;
      s_ok = !rst;
      s_redir = redirect;
      s_tgt = redirect_target;
      s_rvalid = imem_rvalid;
      if (s_ok) begin
        if (id_valid && id_ready) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
          end
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_instr", id_instr, mem_fn(e));
        end
        chk("req_vs_redirect", {31'd0, imem_req & redirect}, 32'd0);
        if (imem_req) begin
          chk("imem_addr", imem_addr, model_fetch);
          chk("req_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
        end
      end
      @(posedge clk); #1;
      if (rst) begin
        exp_q.delete();
        exp_next = RESET_PC;
        model_fetch = RESET_PC;
      end else if (s_ok) begin
        if (s_redir) begin
          chk("redir_pc_wr", {31'd0, pc_wr}, 32'd1);
          chk("redir_pc_next", pc_next, s_tgt);
          chk("redir_flush", {31'd0, id_valid}, 32'd0);
          model_fetch = s_tgt;
          exp_q.delete();
          exp_next = s_tgt;
        end else if (pc_wr) begin
          chk("adv_after_rvalid", {31'd0, s_rvalid}, 32'd1);
          chk("adv_pc_next", pc_next, model_fetch + 32'd4);
          model_fetch = model_fetch + 32'd4;
        end
      end
    end
  end

  task automatic wait_fire(input string name);
    int n;
    n = 0;
    while (redir_fire && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'd0, redir_fire}, 32'd0);
  endtask

  task automatic fire(input logic [31:0] tgt, input int mode);
    redir_tgt_k = tgt;
    redir_mode = mode;
    redir_fire = 1;
  endtask

  // ---------------- directed then random sequence ----------------
  initial begin
    int n;
    int pulses;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // First fetch after reset with a one-cycle memory.
    @(negedge clk); #3;
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, RESET_PC);
    @(posedge clk); @(posedge clk); #1;
    chk("t1_id_valid", {31'd0, id_valid}, 32'd1);
    chk("t1_id_instr", id_instr, 32'h2008_0005);
    chk("t1_id_pc", id_pc, RESET_PC);
    chk("t1_pc_wr", {31'd0, pc_wr}, 32'd1);
    chk("t1_pc_next", pc_next, 32'h0040_0004);
    @(negedge clk); #3;
    chk("t1_req2", {31'd0, imem_req}, 32'd1);
    chk("t1_addr2", imem_addr, 32'h0040_0004);

    // Decode stalls: slot and skid fill, fetching stops.
    ready_pct = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t2_id_valid", {31'd0, id_valid}, 32'd1);
    chk("t2_id_pc", id_pc, 32'h0040_0004);
    chk("t2_state_hold", {29'd0, dbg_state}, {29'd0, ST_HOLD});
    chk("t2_no_req", {31'd0, imem_req}, 32'd0);
    chk("t2_pc_next", pc_next, 32'h0040_000C);
    ready_pct = 100;
    repeat (8) @(posedge clk);
    #1;

    // Redirect while a read is in flight: the late response must be discarded.
    lat_min = 2; lat_max = 2;
    fire(32'h0040_0100, 2);
    wait_fire("t3_fire");
    chk("t3_id_valid", {31'd0, id_valid}, 32'd0);
    chk("t3_pc_wr", {31'd0, pc_wr}, 32'd1);
    chk("t3_pc_next", pc_next, 32'h0040_0100);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (pc_wr) pulses++;
    end
    chk("t3_no_pc_wr_in_drain", 32'(pulses), 32'd0);
    lat_min = 0; lat_max = 0;
    repeat (10) @(posedge clk);
    #1;

    // Redirect coinciding with the response.
    fire(32'h0040_0300, 1);
    wait_fire("t4_fire");
    chk("t4_id_valid", {31'd0, id_valid}, 32'd0);
    chk("t4_pc_wr", {31'd0, pc_wr}, 32'd1);
    chk("t4_pc_next", pc_next, 32'h0040_0300);
    @(posedge clk); #1;
    chk("t4_single_pulse", {31'd0, pc_wr}, 32'd0);
    repeat (8) @(posedge clk);
    #1;

    // Misaligned target faults; a later redirect recovers.
    fire(32'h0040_0102, 0);
    wait_fire("t5_fire");
    chk("t5_pc_next", pc_next, 32'h0040_0102);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_fault", {31'd0, fault}, 32'd1);
    chk("t5_no_req", {31'd0, imem_req}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_fault_sticky", {31'd0, fault}, 32'd1);
    chk("t5_slot_drained", {31'd0, id_valid}, 32'd0);
    fire(32'h0040_0200, 0);
    wait_fire("t5_fire2");
    chk("t5_fault_clear", {31'd0, fault}, 32'd0);
    @(negedge clk); #3;
    chk("t5_req", {31'd0, imem_req}, 32'd1);
    chk("t5_addr", imem_addr, 32'h0040_0200);
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a read.
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!pend && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_pend_seen", {31'd0, pend}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_id_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_pc_next", pc_next, RESET_PC);
    chk("t6_fault", {31'd0, fault}, 32'd0);
    chk("t6_pc_wr", {31'd0, pc_wr}, 32'd0);
    chk("t6_addr", imem_addr, RESET_PC);
    lat_min = 0; lat_max = 0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk); #3;
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_restart_addr", imem_addr, RESET_PC);

    // Randomised traffic.
    rnd_redir_pct = 3;
    for (int seg = 0; seg < 20; seg++) begin
      gnt_pct = $urandom_range(100, 30);
      ready_pct = $urandom_range(100, 20);
      lat_max = $urandom_range(3, 0);
      repeat (150) @(posedge clk);
    end
    rnd_redir_pct = 0;
    ready_pct = 100;
    gnt_pct = 100;
    repeat (20) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
